mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_arb_pick.sv | 27 ++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants for the two-port memory arbiter
// Holds the FSM state encoding, the port-index constants used to address
// one-hot grant vectors, and the default address/line widths.
package mem_arb_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 256;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bundle of cache-port and memory-side signals
// Ports (grouped):
//   p0_* / p1_*   : D-cache / I-cache request (enable, write, addr, data) and
//                   completion (ack, read data)
//   mem_*         : shared memory request outputs and completion inputs
// Modports:
//   slave  : the arbiter's view (cache requests in, memory requests out)
//   master : the surrounding system's view (the reverse directions)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::DEFAULT_ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DEFAULT_DATA_W
);

  logic              p0_enable_i;
  logic              p0_write_i;
  logic [ADDR_W-1:0] p0_addr_i;
  logic [DATA_W-1:0] p0_data_i;
  logic              p0_ack_o;
  logic [DATA_W-1:0] p0_data_o;

  logic              p1_enable_i;
  logic              p1_write_i;
  logic [ADDR_W-1:0] p1_addr_i;
  logic [DATA_W-1:0] p1_data_i;
  logic              p1_ack_o;
  logic [DATA_W-1:0] p1_data_o;

  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_data_i;

  modport slave (
    input  p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
    output p0_ack_o, p0_data_o,
    input  p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
    output p1_ack_o, p1_data_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_ack_i, mem_data_i
  );

  modport master (
    output p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
    input  p0_ack_o, p0_data_o,
    output p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
    input  p1_ack_o, p1_data_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_ack_i, mem_data_i
  );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational two-way winner selection
// Ports:
//   req0_i, req1_i : pending requests from port 0 / port 1
//   ptr_i          : index of the port that wins a tie
//   gnt_o          : one-hot grant, bit PORTx set when port x wins
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req0_i && req1_i) begin
      if (ptr_i) gnt_o[PORT1] = 1'b1;
      else       gnt_o[PORT0] = 1'b1;
    end else if (req0_i) begin
      gnt_o[PORT0] = 1'b1;
    end else if (req1_i) begin
      gnt_o[PORT1] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - D-cache / I-cache arbiter for one shared memory
// Ports:
//   clk_i : clock, all state on rising edge
//   rst_i : synchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (both cache ports plus memory side)
// Build option: MEM_ARB_ROUND_ROBIN_EN adds a 1-bit priority pointer that
// favours the port not last served; without it port 0 always wins ties.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_port_arbiter_if.slave   bus
);

  logic [1:0]        state_q, state_d;
  logic [1:0]        gnt;
  logic              ptr;

  logic              mem_enable;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              p0_ack, p1_ack;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;

  mem_arb_pick u_pick (
    .req0_i (bus.p0_enable_i),
    .req1_i (bus.p1_enable_i),
    .ptr_i  (ptr),
    .gnt_o  (gnt)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  // Only a completed transfer moves priority; an abort leaves it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (bus.mem_ack_i) begin
      if (state_q == GNT0) ptr_d = 1'b1;
      else if (state_q == GNT1) ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mem_enable = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    p0_ack     = 1'b0;
    p1_ack     = 1'b0;
    p0_rdata   = '0;
    p1_rdata   = '0;
    case (state_q)
      IDLE: begin
        // A winner is chosen only here; memory acks seen here are dropped.
        if (gnt[PORT0])      state_d = GNT0;
        else if (gnt[PORT1]) state_d = GNT1;
      end
      GNT0: begin
        mem_enable = bus.p0_enable_i;
        mem_write  = bus.p0_write_i;
        mem_addr   = bus.p0_addr_i;
        mem_wdata  = bus.p0_data_i;
        p0_ack     = bus.mem_ack_i;
        p0_rdata   = bus.mem_data_i;
        // Completion or abort both pass through IDLE so a held enable is
        // arbitrated afresh against the other port.
        if (!bus.p0_enable_i || bus.mem_ack_i) state_d = IDLE;
      end
      GNT1: begin
        mem_enable = bus.p1_enable_i;
        mem_write  = bus.p1_write_i;
        mem_addr   = bus.p1_addr_i;
        mem_wdata  = bus.p1_data_i;
        p1_ack     = bus.mem_ack_i;
        p1_rdata   = bus.mem_data_i;
        if (!bus.p1_enable_i || bus.mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign bus.mem_enable_o = mem_enable;
  assign bus.mem_write_o  = mem_write;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.mem_data_o   = mem_wdata;
  assign bus.p0_ack_o     = p0_ack;
  assign bus.p0_data_o    = p0_rdata;
  assign bus.p1_ack_o     = p1_ack;
  assign bus.p1_data_o    = p1_rdata;

endmodule
